// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the ID-stage control unit.
//   - Mode encodings (ALU, MEM, BR, BLK)
//   - Data-processing opcode constants
//   - EXE_CMD constants driven to the ALU
//   - Sequencer state enum
//   - Helpers decoding a data-processing opcode into an ALU command and a
//     write-back enable.
package cu_pkg;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_BLK = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_WBASE = 2'd2
  } cu_state_e;

  // Unknown opcodes fall back to MOV, matching the single-cycle decoder.
  function automatic logic [3:0] alu_exe_cmd(input logic [3:0] opcode);
    case (opcode)
      OP_MOV:  return EXE_MOV;
      OP_MVN:  return EXE_MVN;
      OP_ADD:  return EXE_ADD;
      OP_ADC:  return EXE_ADC;
      OP_SUB:  return EXE_SUB;
      OP_SBC:  return EXE_SBC;
      OP_AND:  return EXE_AND;
      OP_ORR:  return EXE_ORR;
      OP_EOR:  return EXE_EOR;
      OP_CMP:  return EXE_SUB;
      OP_TST:  return EXE_AND;
      default: return EXE_MOV;
    endcase
  endfunction

  // Compare/test only set flags; everything else writes its result.
  function automatic logic alu_writes_back(input logic [3:0] opcode);
    return !((opcode == OP_CMP) || (opcode == OP_TST));
  endfunction

endpackage

// File: rtl/reg_list_pick.sv
// reg_list_pick: priority encoder over a register list.
//   list       in  NUM_REGS   candidate registers
//   descend    in  1          0: lowest set bit wins, 1: highest set bit wins
//   found      out 1          list has at least one bit set
//   idx        out REG_IDX_W  index of the winning bit (0 when none)
//   clear_mask out NUM_REGS   one-hot mask of the winning bit (0 when none)
module reg_list_pick #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0]  list,
  input  logic                 descend,
  output logic                 found,
  output logic [REG_IDX_W-1:0] idx,
  output logic [NUM_REGS-1:0]  clear_mask
);

  // Ascending: the first hit blocks later ones. Descending: every hit
  // overwrites, so the last (highest) set bit is left standing.
  always_comb begin
    found      = 1'b0;
    idx        = '0;
    clear_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (list[i] && (descend || !found)) begin
        found = 1'b1;
        idx   = REG_IDX_W'(i);
      end
    end
    clear_mask[idx] = found;
  end

endmodule

// File: rtl/block_control_unit.sv
// block_control_unit: ID-stage control unit with block-transfer sequencing.
//
// Modes 00/01/10 decode combinationally with zero latency. Mode 11 expands
// one LDM/STM-style instruction into one memory micro-op per set bit of the
// register list, optionally followed by a base-writeback micro-op, holding
// IF/ID through stallOut while it sequences.
//
// Handshake: validIn qualifies the instruction in IDLE only. Once a block
// transfer is accepted the instruction inputs are ignored until the sequencer
// returns to IDLE; stallOut=1 tells IF/ID to hold for the next cycle.
// freezeIn holds all state and bubbles outputs; flushIn aborts to IDLE and
// wins over freezeIn.
//
// Ports:
//   clk, rst (async active-low)
//   validIn, freezeIn, flushIn, modeIn[1:0], opcodeIn[3:0], SIn, regListIn
//   EXE_CMDOut[3:0], SOut, BOut, MEM_R_ENOut, MEM_W_ENOut, WB_ENOut
//   regSelOut, offsetOut, baseWbOut, stallOut, busyOut
//   state_dbg : current sequencer state
//
// Build option CU_DECREMENT_EN: latches opcode bit1 at accept; when set the
// list is walked highest-first and offsets are negative (two's complement).
module block_control_unit
  import cu_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int REG_IDX_W  = $clog2(NUM_REGS),
  parameter int WORD_BYTES = 4,
  parameter int OFFSET_W   = REG_IDX_W + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 validIn,
  input  logic                 freezeIn,
  input  logic                 flushIn,
  input  logic [1:0]           modeIn,
  input  logic [3:0]           opcodeIn,
  input  logic                 SIn,
  input  logic [NUM_REGS-1:0]  regListIn,
  output logic [3:0]           EXE_CMDOut,
  output logic                 SOut,
  output logic                 BOut,
  output logic                 MEM_R_ENOut,
  output logic                 MEM_W_ENOut,
  output logic                 WB_ENOut,
  output logic [REG_IDX_W-1:0] regSelOut,
  output logic [OFFSET_W-1:0]  offsetOut,
  output logic                 baseWbOut,
  output logic                 stallOut,
  output logic                 busyOut,
  output cu_state_e            state_dbg
);

  localparam logic [OFFSET_W-1:0]  STRIDE  = OFFSET_W'(WORD_BYTES);
  localparam logic [REG_IDX_W:0]   CNT_ONE = (REG_IDX_W+1)'(1);

  cu_state_e             state_q, state_d;
  logic [NUM_REGS-1:0]   list_q, list_d;
  logic [REG_IDX_W:0]    count_q, count_d;
  logic                  load_q, load_d;
  logic                  wb_q, wb_d;
`ifdef CU_DECREMENT_EN
  logic                  desc_q, desc_d;
`endif

  logic                  descend;
  logic [NUM_REGS-1:0]   pick_src;
  logic                  pick_found;
  logic [REG_IDX_W-1:0]  pick_idx;
  logic [NUM_REGS-1:0]   pick_mask;
  logic [NUM_REGS-1:0]   remaining;
  logic [OFFSET_W-1:0]   cnt_ext;
  logic [OFFSET_W-1:0]   up_off;
  logic [OFFSET_W-1:0]   xfer_off;
  logic [OFFSET_W-1:0]   wbase_off;

  // In IDLE the picker looks at the incoming list so the first micro-op
  // issues in the accept cycle; afterwards it walks the latched remainder.
  assign pick_src = (state_q == ST_IDLE) ? regListIn : list_q;

`ifdef CU_DECREMENT_EN
  assign descend = (state_q == ST_IDLE) ? opcodeIn[1] : desc_q;
`else
  assign descend = 1'b0;
`endif

  reg_list_pick #(
    .NUM_REGS  (NUM_REGS),
    .REG_IDX_W (REG_IDX_W)
  ) u_pick (
    .list       (pick_src),
    .descend    (descend),
    .found      (pick_found),
    .idx        (pick_idx),
    .clear_mask (pick_mask)
  );

  assign remaining = pick_src & ~pick_mask;

  // Offsets are count-based: count micro-ops have already been issued.
  assign cnt_ext = (state_q == ST_IDLE) ? '0 : OFFSET_W'(count_q);
  assign up_off  = cnt_ext * STRIDE;

`ifdef CU_DECREMENT_EN
  assign xfer_off  = descend ? ('0 - (up_off + STRIDE)) : up_off;
  assign wbase_off = desc_q  ? ('0 - up_off)            : up_off;
`else
  assign xfer_off  = up_off;
  assign wbase_off = up_off;
`endif

  assign busyOut   = (state_q != ST_IDLE);
  assign state_dbg = state_q;

  always_comb begin
    EXE_CMDOut  = '0;
    SOut        = 1'b0;
    BOut        = 1'b0;
    MEM_R_ENOut = 1'b0;
    MEM_W_ENOut = 1'b0;
    WB_ENOut    = 1'b0;
    regSelOut   = '0;
    offsetOut   = '0;
    baseWbOut   = 1'b0;
    stallOut    = 1'b0;
    state_d     = state_q;
    list_d      = list_q;
    count_d     = count_q;
    load_d      = load_q;
    wb_d        = wb_q;
`ifdef CU_DECREMENT_EN
    desc_d      = desc_q;
`endif

    // While rst is low every output stays at its bubble value.
    if (rst) begin
      if (flushIn) begin
        state_d = ST_IDLE;
        list_d  = '0;
        count_d = '0;
      end else if (freezeIn) begin
        // ID must keep holding the block instruction while frozen mid-walk.
        stallOut = (state_q == ST_XFER);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (validIn) begin
              case (modeIn)
                MODE_ALU: begin
                  EXE_CMDOut = alu_exe_cmd(opcodeIn);
                  SOut       = SIn;
                  WB_ENOut   = alu_writes_back(opcodeIn);
                end
                MODE_MEM: begin
                  EXE_CMDOut  = EXE_ADD;
                  MEM_R_ENOut = SIn;
                  MEM_W_ENOut = ~SIn;
                  WB_ENOut    = SIn;
                end
                MODE_BR: begin
                  BOut = 1'b1;
                end
                MODE_BLK: begin
                  // An empty list is a NOP: bubble and stay in IDLE.
                  if (pick_found) begin
                    EXE_CMDOut  = EXE_ADD;
                    MEM_R_ENOut = SIn;
                    MEM_W_ENOut = ~SIn;
                    WB_ENOut    = SIn;
                    regSelOut   = pick_idx;
                    offsetOut   = xfer_off;
                    list_d      = remaining;
                    count_d     = CNT_ONE;
                    load_d      = SIn;
                    wb_d        = opcodeIn[0];
`ifdef CU_DECREMENT_EN
                    desc_d      = opcodeIn[1];
`endif
                    if (remaining != '0)   state_d = ST_XFER;
                    else if (opcodeIn[0])  state_d = ST_WBASE;
                    else begin
                      state_d = ST_IDLE;
                      count_d = '0;
                    end
                    stallOut = (state_d != ST_IDLE);
                  end
                end
                default: ;
              endcase
            end
          end

          ST_XFER: begin
            EXE_CMDOut  = EXE_ADD;
            MEM_R_ENOut = load_q;
            MEM_W_ENOut = ~load_q;
            WB_ENOut    = load_q;
            regSelOut   = pick_idx;
            offsetOut   = xfer_off;
            list_d      = remaining;
            count_d     = count_q + CNT_ONE;
            if (remaining != '0) state_d = ST_XFER;
            else if (wb_q)       state_d = ST_WBASE;
            else begin
              state_d = ST_IDLE;
              count_d = '0;
            end
            stallOut = (state_d != ST_IDLE);
          end

          ST_WBASE: begin
            EXE_CMDOut = EXE_ADD;
            WB_ENOut   = 1'b1;
            baseWbOut  = 1'b1;
            offsetOut  = wbase_off;
            state_d    = ST_IDLE;
            count_d    = '0;
          end

          default: begin
            state_d = ST_IDLE;
            list_d  = '0;
            count_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      list_q  <= '0;
      count_q <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
`ifdef CU_DECREMENT_EN
      desc_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      count_q <= count_d;
      load_q  <= load_d;
      wb_q    <= wb_d;
`ifdef CU_DECREMENT_EN
      desc_q  <= desc_d;
`endif
    end
  end

endmodule

// File: tb/tb_block_control_unit.sv
// tb_block_control_unit: directed bench for block_control_unit.
// Each driven cycle pushes its expected output vector; a negedge monitor pops
// and compares while the outputs are stable.
module tb_block_control_unit;
  import cu_pkg::*;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;
  localparam int OFFSET_W  = 7;
  localparam int W         = 23;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 validIn, freezeIn, flushIn, SIn;
  logic [1:0]           modeIn;
  logic [3:0]           opcodeIn;
  logic [NUM_REGS-1:0]  regListIn;
  logic [3:0]           EXE_CMDOut;
  logic                 SOut, BOut, MEM_R_ENOut, MEM_W_ENOut, WB_ENOut;
  logic [REG_IDX_W-1:0] regSelOut;
  logic [OFFSET_W-1:0]  offsetOut;
  logic                 baseWbOut, stallOut, busyOut;
  cu_state_e            state_dbg;

  always #5 clk = ~clk;

  block_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .validIn     (validIn),
    .freezeIn    (freezeIn),
    .flushIn     (flushIn),
    .modeIn      (modeIn),
    .opcodeIn    (opcodeIn),
    .SIn         (SIn),
    .regListIn   (regListIn),
    .EXE_CMDOut  (EXE_CMDOut),
    .SOut        (SOut),
    .BOut        (BOut),
    .MEM_R_ENOut (MEM_R_ENOut),
    .MEM_W_ENOut (MEM_W_ENOut),
    .WB_ENOut    (WB_ENOut),
    .regSelOut   (regSelOut),
    .offsetOut   (offsetOut),
    .baseWbOut   (baseWbOut),
    .stallOut    (stallOut),
    .busyOut     (busyOut),
    .state_dbg   (state_dbg)
  );

  // Output vector: exe, S, B, MEM_R, MEM_W, WB, regSel, offset, baseWb, stall, busy
  logic [W-1:0] act;
  assign act = {EXE_CMDOut, SOut, BOut, MEM_R_ENOut, MEM_W_ENOut, WB_ENOut,
                regSelOut, offsetOut, baseWbOut, stallOut, busyOut};

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;

  function automatic logic [W-1:0] pk(input logic [3:0] exe, input logic s, input logic b,
                                      input logic mr, input logic mw, input logic wb,
                                      input logic [3:0] sel, input logic [6:0] off,
                                      input logic bwb, input logic stall, input logic busy);
    return {exe, s, b, mr, mw, wb, sel, off, bwb, stall, busy};
  endfunction

  function automatic logic [W-1:0] e_xfer(input logic load, input logic [3:0] sel,
                                          input logic [6:0] off, input logic stall,
                                          input logic busy);
    return pk(4'b0010, 1'b0, 1'b0, load, !load, load, sel, off, 1'b0, stall, busy);
  endfunction

  function automatic logic [W-1:0] e_wbase(input logic [6:0] off);
    return pk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, off, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic logic [W-1:0] e_bubble(input logic stall, input logic busy);
    return pk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, stall, busy);
  endfunction

  task automatic drive(input logic v, input logic frz, input logic fl, input logic [1:0] m,
                       input logic [3:0] op, input logic s, input logic [15:0] lst);
    validIn   = v;
    freezeIn  = frz;
    flushIn   = fl;
    modeIn    = m;
    opcodeIn  = op;
    SIn       = s;
    regListIn = lst;
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] mon_e;
  string        mon_nm;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      n_cmp++;
      if (act !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", mon_nm, act, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(1, 0, 0, 2'b00, 4'b0100, 0, 16'h0000);
    tick();

    // Reset held with a valid ADD on the inputs: everything stays at 0.
    expect_out("reset_hold", e_bubble(0, 0));
    tick();
    rst = 1'b1;

    // Plain decode table.
    drive(1, 0, 0, 2'b00, 4'b0100, 0, 16'h0000);
    expect_out("alu_add", pk(4'b0010, 0, 0, 0, 0, 1, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(1, 0, 0, 2'b00, 4'b1010, 1, 16'h0000);
    expect_out("alu_cmp", pk(4'b0100, 1, 0, 0, 0, 0, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(1, 0, 0, 2'b00, 4'b1000, 0, 16'h0000);
    expect_out("alu_tst", pk(4'b0110, 0, 0, 0, 0, 0, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(1, 0, 0, 2'b00, 4'b1101, 0, 16'h0000);
    expect_out("alu_mov", pk(4'b0001, 0, 0, 0, 0, 1, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(1, 0, 0, 2'b00, 4'b0001, 1, 16'h0000);
    expect_out("alu_eor", pk(4'b1000, 1, 0, 0, 0, 1, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(1, 0, 0, 2'b00, 4'b1011, 0, 16'h0000);
    expect_out("alu_unknown", pk(4'b0001, 0, 0, 0, 0, 1, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(1, 0, 0, 2'b01, 4'b0000, 1, 16'h0000);
    expect_out("mem_load", pk(4'b0010, 0, 0, 1, 0, 1, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(1, 0, 0, 2'b01, 4'b0000, 0, 16'h0000);
    expect_out("mem_store", pk(4'b0010, 0, 0, 0, 1, 0, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(1, 0, 0, 2'b10, 4'b0000, 1, 16'h0000);
    expect_out("branch", pk(4'b0000, 0, 1, 0, 0, 0, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(0, 0, 0, 2'b00, 4'b0100, 0, 16'h0000);
    expect_out("not_valid", e_bubble(0, 0)); tick();
    drive(1, 1, 0, 2'b00, 4'b0100, 0, 16'h0000);
    expect_out("idle_freeze", e_bubble(0, 0)); tick();
    drive(1, 0, 0, 2'b11, 4'b0001, 1, 16'h0000);
    expect_out("blk_empty_nop", e_bubble(0, 0)); tick();

    // Block load 0x0025 with base writeback; inputs changed to show they are ignored.
    drive(1, 0, 0, 2'b11, 4'b0001, 1, 16'h0025);
    expect_out("ldm_r0", e_xfer(1, 4'd0, 7'd0, 1, 0)); tick();
    drive(1, 0, 0, 2'b00, 4'b0100, 0, 16'hFFFF);
    expect_out("ldm_r2", e_xfer(1, 4'd2, 7'd4, 1, 1)); tick();
    expect_out("ldm_r5", e_xfer(1, 4'd5, 7'd8, 1, 1)); tick();
    expect_out("ldm_wbase", e_wbase(7'd12)); tick();
    expect_out("ldm_done", pk(4'b0010, 0, 0, 0, 0, 1, 4'd0, 7'd0, 0, 0, 0)); tick();

    // opcode bit1 set: descending/negative with the option, ignored without it.
    drive(1, 0, 0, 2'b11, 4'b0011, 1, 16'h0006);
`ifdef CU_DECREMENT_EN
    expect_out("dec_r2", e_xfer(1, 4'd2, 7'h7C, 1, 0)); tick();
    drive(0, 0, 0, 2'b00, 4'b0000, 0, 16'h0000);
    expect_out("dec_r1", e_xfer(1, 4'd1, 7'h78, 1, 1)); tick();
    expect_out("dec_wbase", e_wbase(7'h78)); tick();
`else
    expect_out("asc_r1", e_xfer(1, 4'd1, 7'd0, 1, 0)); tick();
    drive(0, 0, 0, 2'b00, 4'b0000, 0, 16'h0000);
    expect_out("asc_r2", e_xfer(1, 4'd2, 7'd4, 1, 1)); tick();
    expect_out("asc_wbase", e_wbase(7'd8)); tick();
`endif
    expect_out("bit1_done", e_bubble(0, 0)); tick();

    // Store 0x8001 frozen for two cycles after the first micro-op.
    drive(1, 0, 0, 2'b11, 4'b0000, 0, 16'h8001);
    expect_out("stm_r0", e_xfer(0, 4'd0, 7'd0, 1, 0)); tick();
    drive(1, 1, 0, 2'b11, 4'b0000, 0, 16'h8001);
    expect_out("stm_freeze0", e_bubble(1, 1)); tick();
    expect_out("stm_freeze1", e_bubble(1, 1)); tick();
    drive(1, 0, 0, 2'b11, 4'b0000, 0, 16'h8001);
    expect_out("stm_r15", e_xfer(0, 4'd15, 7'd4, 0, 1)); tick();
    drive(0, 0, 0, 2'b00, 4'b0000, 0, 16'h0000);
    expect_out("stm_done", e_bubble(0, 0)); tick();

    // Full list aborted by a flush on the third cycle.
    drive(1, 0, 0, 2'b11, 4'b0001, 1, 16'hFFFF);
    expect_out("flush_r0", e_xfer(1, 4'd0, 7'd0, 1, 0)); tick();
    expect_out("flush_r1", e_xfer(1, 4'd1, 7'd4, 1, 1)); tick();
    drive(1, 0, 1, 2'b11, 4'b0001, 1, 16'hFFFF);
    expect_out("flush_cut", e_bubble(0, 1)); tick();
    drive(0, 0, 0, 2'b00, 4'b0000, 0, 16'h0000);
    expect_out("flush_idle", e_bubble(0, 0)); tick();

    // Flush and freeze together: flush wins.
    drive(1, 0, 0, 2'b11, 4'b0000, 1, 16'h0003);
    expect_out("ff_r0", e_xfer(1, 4'd0, 7'd0, 1, 0)); tick();
    drive(1, 1, 1, 2'b11, 4'b0000, 1, 16'h0003);
    expect_out("ff_cut", e_bubble(0, 1)); tick();
    drive(0, 0, 0, 2'b00, 4'b0000, 0, 16'h0000);
    expect_out("ff_idle", e_bubble(0, 0)); tick();

    // Full list store, no writeback: 16 micro-ops, last offset 60.
    drive(1, 0, 0, 2'b11, 4'b0000, 0, 16'hFFFF);
    for (int i = 0; i < NUM_REGS; i++) begin
      logic [3:0] sel;
      logic [6:0] off;
      sel = 4'(i);
      off = 7'(i * 4);
      expect_out($sformatf("full_r%0d", i), e_xfer(0, sel, off, (i != 15), (i != 0)));
      tick();
      if (i == 0) drive(0, 0, 0, 2'b00, 4'b0000, 0, 16'h0000);
    end
    expect_out("full_done", e_bubble(0, 0)); tick();

    // Asynchronous reset in the middle of a transfer.
    drive(1, 0, 0, 2'b11, 4'b0000, 1, 16'h00F0);
    expect_out("rst_r4", e_xfer(1, 4'd4, 7'd0, 1, 0)); tick();
    expect_out("rst_r5", e_xfer(1, 4'd5, 7'd4, 1, 1)); tick();
    rst = 1'b0;
    drive(1, 0, 0, 2'b00, 4'b0100, 0, 16'h0000);
    expect_out("rst_async", e_bubble(0, 0)); tick();
    rst = 1'b1;
    expect_out("rst_release", pk(4'b0010, 0, 0, 0, 0, 1, 4'd0, 7'd0, 0, 0, 0)); tick();
    drive(0, 0, 0, 2'b00, 4'b0000, 0, 16'h0000);
    expect_out("rst_no_more", e_bubble(0, 0)); tick();

    tick();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/block_control_unit.md
Name: block_control_unit

Overview:
- Parametrised successor to the ID-stage control unit of the pipelined ARM core.
- Decodes mode/opcode/S into EX/MEM/WB control exactly as the single-cycle decoder does for modes 00/01/10.
- Adds mode 11 (block transfer, LDM/STM-style): one instruction expands into one memory micro-op per set bit of a register list, plus an optional base-writeback micro-op.
- Holds IF/ID via a stall output while it sequences.

Parameters:
- NUM_REGS, 16, width of register list and number of architectural registers.
- REG_IDX_W, $clog2(NUM_REGS), width of register index output.
- WORD_BYTES, 4, byte stride per transferred register.
- OFFSET_W, REG_IDX_W+3, width of byte offset output (holds NUM_REGS*WORD_BYTES).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- validIn  in  1  ID holds a valid instruction.
- freezeIn  in  1  pipeline hazard freeze; sequencer holds state, outputs forced to bubble.
- flushIn  in  1  branch-taken flush; aborts any sequence.
- modeIn  in  2  instruction mode field.
- opcodeIn  in  4  opcode; in mode 11: bit0 = base writeback, bit1 = decrement (feature only).
- SIn  in  1  S bit; in mode 11: 1 = load, 0 = store.
- regListIn  in  NUM_REGS  register list (mode 11 only).
- EXE_CMDOut  out  4  ALU command.
- SOut, BOut, MEM_R_ENOut, MEM_W_ENOut, WB_ENOut  out  1 each  control bits.
- regSelOut  out  REG_IDX_W  register index of the current transfer.
- offsetOut  out  OFFSET_W  byte offset from base for the current micro-op.
- baseWbOut  out  1  current micro-op writes the updated base.
- stallOut  out  1  hold IF/ID next cycle.
- busyOut  out  1  sequencer not IDLE.

Behaviour:
- Reset (rst=0, async): state IDLE, pending list 0, count 0. All outputs 0, including EXE_CMDOut=0000 and stallOut=0.
- Bubble: all control outputs 0. Forced when validIn=0, freezeIn=1 or flushIn=1. Freeze holds state; flush returns to IDLE and clears the pending list and count in the same cycle.
- IDLE, modes 00/01/10: purely combinational, zero latency, identical table to the existing decoder.
  - Mode 00: SOut=SIn; WB_EN=0 for CMP/TST, else 1.
  - Mode 01: WB=MEM_R=SIn, MEM_W=~SIn, EXE_CMD=ADD.
  - Mode 10: BOut=1.
  - Unknown opcode: EXE_CMD=0001.
  - stallOut=0.
- IDLE, mode 11, regListIn==0: bubble, no state change (NOP).
- IDLE, mode 11, nonzero list:
  - Issue the first micro-op this cycle on the lowest set bit i: EXE_CMD=0010, MEM_R=SIn, MEM_W=~SIn, WB_EN=SIn, regSel=i, offset=0.
  - Latch list with bit i cleared and count=1.
  - Next state is XFER if bits remain, WBASE if only writeback remains, otherwise IDLE.
  - stallOut=1 unless the next state is IDLE.
- XFER:
  - Each unfrozen cycle issues the lowest remaining bit: offset=count*WORD_BYTES, then clear the bit and increment count.
  - Instruction inputs are ignored; ID is held by the stall.
  - On the last bit, go to WBASE if opcode bit0 was latched, else IDLE. stallOut=0 on the issuing cycle of the final micro-op.
- WBASE: one cycle with EXE_CMD=0010, WB_EN=1, baseWbOut=1, MEM_*=0, offset=count*WORD_BYTES (total bytes); stallOut=0; next state IDLE.
- busyOut=1 in XFER and WBASE.
- Full list (all NUM_REGS bits set): NUM_REGS micro-ops; the final offset is (NUM_REGS-1)*WORD_BYTES and fits in OFFSET_W.
- Simultaneous flushIn and freezeIn: flush wins.
- Reset mid-sequence: immediate return to IDLE, no further micro-ops.

Optional Feature:
- Macro CU_DECREMENT_EN.
- Defined: opcode bit1 latched at accept. When set, registers are issued highest-index first and offsets are negative. offsetOut is two's complement -(count+1)*WORD_BYTES for transfers and -total for WBASE.
- Not defined: bit1 ignored, ascending order only, no decrement logic synthesised.

Decomposition:
- Shared package cu_pkg:
  - EXE_CMD constants (MOV 0001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MVN 1001).
  - Mode encodings (ALU 00, MEM 01, BR 10, BLK 11).
  - Opcode constants.
  - State enum (IDLE, XFER, WBASE).
- Sub-module reg_list_pick: parametrised priority encoder returning the lowest (or highest, with the feature) set index plus a one-hot clear mask.

Test Plan:
- Reset mid-XFER with list 0x00F0 -> all outputs 0 asynchronously; after release, mode 00 opcode 0100 -> EXE_CMD 0010, WB_EN 1, stallOut 0.
- Mode 00 opcode 1010 SIn=1 -> EXE_CMD 0100, SOut 1, WB_EN 0; mode 10 -> BOut 1, others 0.
- Mode 11, SIn=1, list 0x0025, opcode bit0=1:
  - regSel 0,2,5 with offsets 0,4,8 and MEM_R=WB_EN=1.
  - Then WBASE with offset 12, baseWbOut 1.
  - stallOut 1,1,1,0 over the four cycles.
- Mode 11 store, list 0x8001, freezeIn high for 2 cycles after the first op -> bubble outputs during freeze, then regSel 15 offset 4 MEM_W 1.
- Mode 11 list 0xFFFF, flushIn on 3rd cycle -> only 2 micro-ops issued, IDLE next cycle, stallOut 0.
- With CU_DECREMENT_EN, opcode bit1=1, list 0x0006, bit0=1 -> regSel 2 offset -4, regSel 1 offset -8, WBASE offset -8.
